inst_mem_fetch: RTL and testbench
=================================

// Module: inst_mem_fetch
// PURPOSE
//   Parametrised instruction memory with a valid/ready fetch interface and registered read.
//   Returns FETCH_W consecutive 32-bit instructions per request, with per-lane valid mask.
//   Flags misaligned and out-of-range accesses, and supports a flush for branch redirect.
//   Sits between the IF-stage PC logic and the IF/ID register. A separate write port loads the program.
// PARAMETERS
//   DEPTH    1024  number of 32-bit words; need not be a power of two
//   FETCH_W  2     instructions returned per fetch (1, 2 or 4)
//   AW       32    byte-address width of req_addr and wr_addr
// PORTS
//   clk        in   1          clock; all state updates on rising edge
//   rst        in   1          synchronous, active-high reset
//   wr_en      in   1          program-load write strobe
//   wr_addr    in   AW         byte address of write
//   wr_data    in   32         instruction to write
//   wr_err     out  1          1-cycle pulse: last write dropped (misaligned/out of range)
//   flush      in   1          discard held response (PC redirect)
//   req_valid  in   1          fetch request valid
//   req_ready  out  1          fetch request accepted when req_valid&req_ready
//   req_addr   in   AW         byte PC of first instruction
//   rsp_valid  out  1          response valid
//   rsp_ready  in   1          consumer accepts response
//   rsp_addr   out  AW         echo of accepted req_addr
//   rsp_inst   out  32*FETCH_W lane k at bits [32k+31:32k] = mem[(req_addr>>2)+k]
//   rsp_mask   out  FETCH_W    lane k holds a real instruction
//   rsp_fault  out  2          [0] misaligned (req_addr[1:0]!=0), [1] word index >= DEPTH
// BEHAVIOUR
// - Reset: rsp_valid=0, rsp_addr=0, rsp_inst=0, rsp_mask=0, rsp_fault=0, wr_err=0.
//   Memory array is not reset; contents persist across rst.
// - req_ready = !rsp_valid | rsp_ready | flush. It is combinational and never depends on req_valid.
// - Accept (req_valid&req_ready): on the next edge, rsp_valid=1 and all rsp_* are loaded.
//   Latency is exactly 1 cycle.
// - Hold: when rsp_valid&!rsp_ready&!flush, all rsp_* stay stable.
// - Consume without new accept: rsp_valid->0. Other rsp_* fields keep their values.
// - Flush with no accept: rsp_valid->0 next edge. Flush with accept: the new response replaces the old one.
// - Lane rules, with w = req_addr>>2:
//   - misaligned: fault[0]=1, mask=0, inst=0. Fault[1] is still evaluated.
//   - w >= DEPTH: fault[1]=1, mask=0, inst=0.
//   - otherwise: lane k valid iff w+k < DEPTH. Invalid lanes read 0. There is no wrap-around.
// - Write: mem[wr_addr>>2] <= wr_data when wr_en, wr_addr[1:0]==0 and index < DEPTH.
//   Otherwise the write is dropped and wr_err=1 next cycle.
// - Same-edge write and accepted read of the same word: the response returns the OLD contents.
//   The new contents are visible to requests accepted on later edges.
// - Reset mid-operation: a pending response is discarded. A same-cycle req is not accepted
//   (req_ready may read 1, but rst wins). A same-cycle write IS performed.
// TESTING
// 1. rst held 2 cycles -> rsp_valid=0, wr_err=0, rsp_inst=0. Release rst; req_valid=1 -> req_ready=1.
// 2. Write 0x00000013@0x0, 0x00500093@0x4. Fetch 0x0 ->
//    next cycle rsp_inst={0x00500093,0x00000013}, mask=2'b11, fault=0, rsp_addr=0.
// 3. rsp_ready=0 for 3 cycles after a response -> rsp_* stable and req_ready=0.
//    rsp_ready=1 with new req 0x8 -> back-to-back response, no bubble.
// 4. Fetch 0xFFC (w=1023, DEPTH=1024) -> mask=2'b01. Fetch 0x1000 -> fault=2'b10, mask=0.
//    Fetch 0x2 -> fault=2'b01, inst=0.
// 5. Write 0xDEADBEEF@0x10 on the same edge as fetch 0x10 -> response holds old word.
//    Refetch -> 0xDEADBEEF. Write @0x11 -> wr_err pulse, memory unchanged.
// 6. Stalled response with flush=1 and no req -> rsp_valid=0 next cycle.
//    flush with req 0x20 -> response for 0x20 only. rst while rsp_valid=1 -> rsp_valid=0.

Source files
------------

// File: rtl/inst_mem_fetch.sv
// Instruction memory with a valid/ready fetch port and a separate program-load
// write port. Each accepted fetch returns FETCH_W consecutive 32-bit words one
// cycle later, with a per-lane valid mask and misaligned/out-of-range faults.
module inst_mem_fetch #(
  parameter int DEPTH   = 1024,
  parameter int FETCH_W = 2,
  parameter int AW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  // program-load write port
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [31:0]          wr_data,
  output logic                 wr_err,
  // fetch request
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AW-1:0]        req_addr,
  // fetch response
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [AW-1:0]        rsp_addr,
  output logic [32*FETCH_W-1:0] rsp_inst,
  output logic [FETCH_W-1:0]   rsp_mask,
  output logic [1:0]           rsp_fault
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  // Program storage; not reset so contents survive rst.
  logic [31:0] mem [DEPTH];

  // Word indices keep the full address range so out-of-range indices are
  // detected instead of aliasing onto low addresses.
  logic [AW-1:0] req_word;
  logic [AW-1:0] wr_word;
  logic          req_mis;
  logic          req_oor;
  logic          wr_ok;
  logic          accept;

  logic          rsp_valid_reg;
  logic          rsp_valid_next;
  logic [AW-1:0] rsp_addr_reg;
  logic [FETCH_W-1:0] rsp_mask_reg;
  logic [1:0]    rsp_fault_reg;
  logic          wr_err_reg;
  logic [FETCH_W-1:0] lane_ok_vec;

  assign req_word = {2'b00, req_addr[AW-1:2]};
  assign wr_word  = {2'b00, wr_addr[AW-1:2]};
  assign req_mis  = (req_addr[1:0] != 2'b00);
  assign req_oor  = (req_word >= DEPTH_A);
  assign wr_ok    = wr_en && (wr_addr[1:0] == 2'b00) && (wr_word < DEPTH_A);

  // The slot can take a new request whenever the held response is leaving.
  assign req_ready = !rsp_valid_reg || rsp_ready || flush;
  // Reset overrides acceptance even though req_ready may read 1.
  assign accept    = req_valid && req_ready && !rst;

  // Program-load write; performed even while rst is asserted.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_word[IW-1:0]] <= wr_data;
    end
  end

  // Dropped-write indicator, one cycle after the offending strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= wr_en && !wr_ok;
    end
  end

  // Per-lane registered read. Reads see the pre-edge memory contents, so a
  // same-edge write to the fetched word returns the old instruction.
  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
    logic [AW-1:0] lane_word;
    logic          lane_ok;
    logic [31:0]   lane_inst_reg;

    assign lane_word       = req_word + AW'(gi);
    assign lane_ok         = !req_mis && !req_oor && (lane_word < DEPTH_A);
    assign lane_ok_vec[gi] = lane_ok;
    assign rsp_inst[32*gi +: 32] = lane_inst_reg;

    // Load the lane word on accept; lanes past the end read as zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_inst_reg <= 32'h0;
      end else if (accept) begin
        lane_inst_reg <= lane_ok ? mem[lane_word[IW-1:0]] : 32'h0;
      end
    end
  end

  // Response-valid next state: load on accept, drop when consumed or flushed.
  always_comb begin
    rsp_valid_next = rsp_valid_reg;
    if (accept) begin
      rsp_valid_next = 1'b1;
    end else if (rsp_ready || flush) begin
      rsp_valid_next = 1'b0;
    end
  end

  // Response registers; metadata only changes on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_addr_reg  <= '0;
      rsp_mask_reg  <= '0;
      rsp_fault_reg <= 2'b00;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      if (accept) begin
        rsp_addr_reg  <= req_addr;
        rsp_mask_reg  <= lane_ok_vec;
        rsp_fault_reg <= {req_oor, req_mis};
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_addr  = rsp_addr_reg;
  assign rsp_mask  = rsp_mask_reg;
  assign rsp_fault = rsp_fault_reg;
  assign wr_err    = wr_err_reg;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Scoreboard bench for inst_mem_fetch: the driver pushes expected responses
// computed from a word-array reference model; a negedge monitor compares.
module tb_inst_mem_fetch;

  localparam int DEPTH = 1024;
  localparam int FW    = 2;
  localparam int AW    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic              wr_err;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [AW-1:0]     rsp_addr;
  logic [32*FW-1:0]  rsp_inst;
  logic [FW-1:0]     rsp_mask;
  logic [1:0]        rsp_fault;

  inst_mem_fetch #(.DEPTH(DEPTH), .FETCH_W(FW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .flush(flush), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_inst(rsp_inst), .rsp_mask(rsp_mask), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [32*FW-1:0] inst;
    logic [FW-1:0]    mask;
    logic [1:0]       fault;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mm [DEPTH];
  logic        mv = 1'b0;          // model: response held after the next edge
  logic        exp_wr_err = 1'b0;  // model: wr_err after the next edge
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected fetch result straight from the lane rules.
  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    longint unsigned w;
    w = longint'(a) >> 2;
    e.addr  = a;
    e.inst  = '0;
    e.mask  = '0;
    e.fault = {(w >= DEPTH), (a[1:0] != 2'b00)};
    if (e.fault == 2'b00) begin
      for (int k = 0; k < FW; k++) begin
        if (w + k < DEPTH) begin
          e.inst[32*k +: 32] = mm[w + k];
          e.mask[k] = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // One clock cycle of stimulus plus model update.
  task automatic step(input logic r, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd, input logic fl, input logic rv,
                      input logic [31:0] ra, input logic rr);
    logic exp_ready;
    longint unsigned ww;
    @(posedge clk);
    #1;
    chk("rsp_valid", 128'(rsp_valid), 128'(mv));
    chk("wr_err", 128'(wr_err), 128'(exp_wr_err));
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    flush = fl; req_valid = rv; req_addr = ra; rsp_ready = rr;
    #1;
    exp_ready = !mv || rr || fl;
    chk("req_ready", 128'(req_ready), 128'(exp_ready));
    if (rv && exp_ready && !r) begin
      sbq.push_back(model(ra));   // built before this cycle's write lands
      mv = 1'b1;
    end else if (r || rr || fl) begin
      mv = 1'b0;
    end
    ww = longint'(wa) >> 2;
    if (we && wa[1:0] == 2'b00 && ww < DEPTH) begin
      mm[ww] = wd;
      exp_wr_err = 1'b0;
    end else begin
      exp_wr_err = we && !r;
    end
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, rr);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, a, rr);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic chk_reset_fields();
    chk("rst_rsp_inst", 128'(rsp_inst), 128'(0));
    chk("rst_rsp_addr", 128'(rsp_addr), 128'(0));
    chk("rst_rsp_mask", 128'(rsp_mask), 128'(0));
    chk("rst_rsp_fault", 128'(rsp_fault), 128'(0));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 8)
      0:       return $urandom;
      1:       return 32'(DEPTH*4 - 8 + $urandom_range(0, 16));
      2:       return 32'($urandom_range(0, DEPTH*4 - 1));
      default: return 32'($urandom_range(0, DEPTH - 1) * 4);
    endcase
  endfunction

  // Monitor: compare the presented response with the scoreboard head every
  // cycle it is shown, and retire it when it leaves (consumed, flushed, reset).
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 128'(1), 128'(0));
        end else begin
          chk("rsp_addr", 128'(rsp_addr), 128'(sbq[0].addr));
          chk("rsp_inst", 128'(rsp_inst), 128'(sbq[0].inst));
          chk("rsp_mask", 128'(rsp_mask), 128'(sbq[0].mask));
          chk("rsp_fault", 128'(rsp_fault), 128'(sbq[0].fault));
          if (rsp_ready || flush || rst) begin
            $display("rsp addr=%08h inst=%016h mask=%b fault=%b%s", rsp_addr, rsp_inst,
                     rsp_mask, rsp_fault, (rsp_ready ? "" : " (dropped)"));
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    // reset held two cycles
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_reset_fields();

    // load every word so all reads have defined contents
    for (int i = 0; i < DEPTH; i++) write(32'(i*4), $urandom);

    // first fetch after reset, then basic two-lane fetch
    write(32'h0, 32'h0000_0013);
    write(32'h4, 32'h0050_0093);
    fetch(32'h0, 1'b1);
    idle(1'b1);

    // stall three cycles with a pending request, then back-to-back
    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b0);
    fetch(32'h4, 1'b0);
    fetch(32'h4, 1'b0);
    fetch(32'h8, 1'b1);
    fetch(32'hC, 1'b1);
    idle(1'b1);

    // boundaries: last word, first out-of-range word, misaligned
    fetch(32'hFFC, 1'b1);
    fetch(32'h1000, 1'b1);
    fetch(32'h2, 1'b1);
    fetch(32'hFFE, 1'b1);
    idle(1'b1);

    // same-edge write and read, refetch, dropped misaligned write
    step(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h10, 1'b1);
    fetch(32'h10, 1'b1);
    write(32'h11, 32'h1234_5678);
    write(32'h1000, 32'h1234_5678);
    fetch(32'h10, 1'b1);
    idle(1'b1);

    // flush without request, flush with request
    fetch(32'h18, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    fetch(32'h18, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b0);
    idle(1'b1);

    // reset while a response is held: request refused, write performed
    fetch(32'h24, 1'b0);
    step(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h28, 1'b0);
    idle(1'b1);
    chk_reset_fields();
    fetch(32'h30, 1'b1);
    idle(1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 40) == 0, ($urandom % 4) == 0, rand_addr(), $urandom,
           ($urandom % 10) == 0, ($urandom % 4) != 0, rand_addr(), ($urandom % 4) != 0);
    end

    // drain
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk);
    #2;
    chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
